elastic_pipe_reg: RTL and testbench

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

---
 rtl/pipe_pkg.sv | 12 +
 rtl/elastic_pipe_reg.sv | 99 +++++++++
 tb/tb_elastic_pipe_reg.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline register: state encoding and occupancy width.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage: a single register, or a two-entry skid buffer when SKID_EN=1.
// Valid/ready handshake on both sides, with flush support and bubble-zeroed control bits.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 16,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_t       state, state_nx;
  logic [DATA_W-1:0] head_data, skid_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic              push_evt, pop_evt;

  assign push_evt = in_valid & in_ready;
  assign pop_evt  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push_evt) state_nx = ONE;
        ONE: begin
          if (push_evt && !pop_evt && SKID_EN != 0) state_nx = TWO;
          else if (!push_evt && pop_evt)            state_nx = EMPTY;
        end
        TWO:     if (pop_evt) state_nx = ONE;
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Payload registers freeze on flush so out_data keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data <= '0;
      head_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (!flush) begin
      unique case (state)
        EMPTY: begin
          if (push_evt) begin
            head_data <= in_data;
            head_ctrl <= in_ctrl;
          end
        end
        ONE: begin
          if (push_evt && pop_evt) begin
            head_data <= in_data;
            head_ctrl <= in_ctrl;
          end else if (push_evt && SKID_EN != 0) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end
        end
        TWO: begin
          if (pop_evt) begin
            head_data <= skid_data;
            head_ctrl <= skid_ctrl;
          end
        end
        default: ;
      endcase
    end
  end

  // With the skid buffer, in_ready decodes state only, so no path from out_ready.
  always_comb begin
    out_valid = (state != EMPTY);
    if (SKID_EN != 0) in_ready = (state != TWO);
    else              in_ready = !out_valid || out_ready;
    out_data  = head_data;
    out_ctrl  = out_valid ? head_ctrl : '0;
    occupancy = state;
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed and random checks of elastic_pipe_reg in skid (dut_a) and single-register (dut_b) modes.
// Both instances share one stimulus; each has its own expected values and scoreboard.
module tb_elastic_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [15:0] a_out_ctrl, b_out_ctrl;
  logic [1:0]  a_occ, b_occ;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [47:0] qa[$];
  logic [47:0] qb[$];

  always #5 clk = ~clk;

  elastic_pipe_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ)
  );

  elastic_pipe_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [15:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    cyc();
  endtask

  // Reset is held with junk on the inputs, which must be ignored.
  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hdead_beef; in_ctrl = 16'hffff;
    cyc();
    cyc();
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_data",  a_out_data, 0);
    check("rst_a_ctrl",  a_out_ctrl, 0);
    check("rst_a_occ",   a_occ, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_b_ready", b_in_ready, 1);

    // First-entry latency
    in_valid = 1'b1; in_data = 32'h0040_0000; in_ctrl = 16'h00a5; out_ready = 1'b1;
    @(negedge clk);
    check("lat_a_ready", a_in_ready, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_a_valid", a_out_valid, 1);
    check("lat_a_data",  a_out_data, 32'h0040_0000);
    check("lat_a_ctrl",  a_out_ctrl, 16'h00a5);
    check("lat_a_occ",   a_occ, 1);
    check("lat_b_data",  b_out_data, 32'h0040_0000);
    cyc();
    @(negedge clk);
    check("lat_a_drain_valid", a_out_valid, 0);
    check("lat_a_drain_ctrl",  a_out_ctrl, 0);

    // Skid fill, stall stability, ordered drain
    do_reset();
    push(32'h11, 16'h0001);
    push(32'h22, 16'h0002);
    in_valid = 1'b1; in_data = 32'h33; in_ctrl = 16'h0003;
    @(negedge clk);
    check("skid_occ2",    a_occ, 2);
    check("skid_ready0",  a_in_ready, 0);
    check("skid_head",    a_out_data, 32'h11);
    cyc();
    @(negedge clk);
    check("skid_hold_data", a_out_data, 32'h11);
    check("skid_hold_ctrl", a_out_ctrl, 16'h0001);
    check("skid_hold_occ",  a_occ, 2);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("skid_drain0", a_out_data, 32'h11);
    cyc();
    @(negedge clk);
    check("skid_drain1_data",  a_out_data, 32'h22);
    check("skid_drain1_ctrl",  a_out_ctrl, 16'h0002);
    check("skid_drain1_occ",   a_occ, 1);
    check("skid_drain1_ready", a_in_ready, 1);
    cyc();
    @(negedge clk);
    check("skid_empty_valid", a_out_valid, 0);
    check("skid_empty_occ",   a_occ, 0);

    // Flush while full with a simultaneous push
    do_reset();
    push(32'h11, 16'h0001);
    push(32'h22, 16'h0002);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; in_ctrl = 16'h0009;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", a_out_valid, 0);
    check("flush_ctrl",  a_out_ctrl, 0);
    check("flush_occ",   a_occ, 0);
    check("flush_ready", a_in_ready, 1);
    check("flush_data_kept", a_out_data, 32'h11);
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    check("flush_no_ghost1", a_out_valid, 0);
    cyc();
    @(negedge clk);
    check("flush_no_ghost2", a_out_valid, 0);

    // Single-register mode: combinational ready and full throughput
    do_reset();
    in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h0005;
    @(negedge clk);
    check("ns_ready_empty", b_in_ready, 1);
    cyc();
    in_data = 32'h66; in_ctrl = 16'h0006;
    @(negedge clk);
    check("ns_valid", b_out_valid, 1);
    check("ns_ready_stall", b_in_ready, 0);
    check("ns_head", b_out_data, 32'h55);
    out_ready = 1'b1;
    #1;
    check("ns_ready_go", b_in_ready, 1);
    cyc();
    in_data = 32'h77; in_ctrl = 16'h0007;
    @(negedge clk);
    check("ns_tp1_data", b_out_data, 32'h66);
    check("ns_tp1_occ",  b_occ, 1);
    check("ns_tp1_ready", b_in_ready, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("ns_tp2_data", b_out_data, 32'h77);
    check("ns_tp2_ctrl", b_out_ctrl, 16'h0007);
    cyc();
    @(negedge clk);
    check("ns_empty", b_out_valid, 0);

    // Reset while full, flush asserted too: reset wins and clears payload
    do_reset();
    push(32'h11, 16'h0001);
    push(32'h22, 16'h0002);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'haa; in_ctrl = 16'h000a;
    cyc();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("mrst_valid", a_out_valid, 0);
    check("mrst_data",  a_out_data, 0);
    check("mrst_ctrl",  a_out_ctrl, 0);
    check("mrst_occ",   a_occ, 0);
    check("mrst_ready", a_in_ready, 1);

    // Random handshake traffic against per-instance scoreboards
    do_reset();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = $urandom;
      in_ctrl   = 16'($urandom);
      @(negedge clk);
      check("rnd_a_occ", a_occ, qa.size());
      check("rnd_a_ready", a_in_ready, (qa.size() < 2));
      if (!a_out_valid) check("rnd_a_bubble", a_out_ctrl, 0);
      if (a_out_valid && out_ready) begin
        if (qa.size() == 0) check("rnd_a_extra", 1, 0);
        else check("rnd_a_out", {a_out_ctrl, a_out_data}, qa.pop_front());
      end
      if (in_valid && a_in_ready) qa.push_back({in_ctrl, in_data});

      check("rnd_b_occ", b_occ, qb.size());
      check("rnd_b_ready", b_in_ready, (qb.size() == 0) || out_ready);
      if (!b_out_valid) check("rnd_b_bubble", b_out_ctrl, 0);
      if (b_out_valid && out_ready) begin
        if (qb.size() == 0) check("rnd_b_extra", 1, 0);
        else check("rnd_b_out", {b_out_ctrl, b_out_data}, qb.pop_front());
      end
      if (in_valid && b_in_ready) qb.push_back({in_ctrl, in_data});
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
